// File: rtl/seq_pattern_pkg.sv
// Shared types and constants for the seq_pattern arbiter slice.
package seq_pattern_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_RESP
    } arb_state_t;

    localparam int PERF_W = 16;

endpackage

// File: rtl/seq_pattern_eval.sv
// Shared pattern evaluator: on load, registers y = (a & b) | ~c, bitwise.
module seq_pattern_eval #(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] y
);

    // Single result register, refreshed only when the sequencer loads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= '0;
        end else if (load) begin
            y <= (a & b) | ~c;
        end
    end

endmodule

// File: rtl/seq_pattern_arbiter.sv
// Round-robin arbiter and IDLE/GRANT/RESP sequencer sharing one pattern
// evaluator among N_REQ requesters.
// Optional macro SEQ_ARB_PERF_EN adds perf_grants/perf_stall counters.
module seq_pattern_arbiter
    import seq_pattern_pkg::*;
#(
    parameter  int N_REQ  = 4,
    parameter  int DATA_W = 1,
    localparam int TAG_W  = $clog2(N_REQ)
) (
    input  logic                    blif_clk_net,
    input  logic                    blif_reset_net,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] op_a,
    input  logic [N_REQ*DATA_W-1:0] op_b,
    input  logic [N_REQ*DATA_W-1:0] op_c,
    output logic [N_REQ-1:0]        gnt,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [TAG_W-1:0]        rsp_tag,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    busy
`ifdef SEQ_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0]       perf_grants,
    output logic [PERF_W-1:0]       perf_stall
`endif
);

    arb_state_t        state;
    arb_state_t        state_nx;
    logic [TAG_W-1:0]  rr_ptr;
    logic [TAG_W-1:0]  win_q;
    logic [TAG_W-1:0]  win_sel;
    logic [TAG_W-1:0]  win_hi;
    logic [TAG_W-1:0]  win_lo;
    logic              found_hi;
    logic              found_lo;
    logic              load;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [DATA_W-1:0] sel_c;

    // Round-robin pick: lowest requester at or above rr_ptr, otherwise the
    // lowest requester overall (the wrap past N_REQ-1 back to 0).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req[i]) begin
                if (!found_lo) begin
                    found_lo = 1'b1;
                    win_lo   = TAG_W'(i);
                end
                if (!found_hi && (TAG_W'(i) >= rr_ptr)) begin
                    found_hi = 1'b1;
                    win_hi   = TAG_W'(i);
                end
            end
        end
        win_sel = found_hi ? win_hi : win_lo;
    end

    // Operand mux for the latched winner.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_c = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win_q == TAG_W'(i)) begin
                sel_a = op_a[i*DATA_W +: DATA_W];
                sel_b = op_b[i*DATA_W +: DATA_W];
                sel_c = op_c[i*DATA_W +: DATA_W];
            end
        end
    end

    // Sequencer next state and per-state outputs.
    always_comb begin
        state_nx  = state;
        gnt       = '0;
        load      = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            ARB_IDLE: begin
                busy = 1'b0;
                if (|req) begin
                    state_nx = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                load = 1'b1;
                for (int unsigned i = 0; i < N_REQ; i++) begin
                    if (win_q == TAG_W'(i)) begin
                        gnt[i] = 1'b1;
                    end
                end
                state_nx = ARB_RESP;
            end
            ARB_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nx = ARB_IDLE;
                end
            end
            default: state_nx = ARB_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Winner latched at arbitration; tag and pointer advance in GRANT.
    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            win_q   <= '0;
            rr_ptr  <= '0;
            rsp_tag <= '0;
        end else begin
            if ((state == ARB_IDLE) && (|req)) begin
                win_q <= win_sel;
            end
            if (state == ARB_GRANT) begin
                rsp_tag <= win_q;
                rr_ptr  <= (win_q == TAG_W'(N_REQ - 1)) ? '0 : win_q + TAG_W'(1);
            end
        end
    end

    seq_pattern_eval #(
        .DATA_W (DATA_W)
    ) u_eval (
        .clk   (blif_clk_net),
        .rst_n (blif_reset_net),
        .load  (load),
        .a     (sel_a),
        .b     (sel_b),
        .c     (sel_c),
        .y     (rsp_data)
    );

`ifdef SEQ_ARB_PERF_EN
    // Saturating counts of accepted responses and stalled RESP cycles.
    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            perf_grants <= '0;
            perf_stall  <= '0;
        end else begin
            if (rsp_valid && rsp_ready && (perf_grants != '1)) begin
                perf_grants <= perf_grants + PERF_W'(1);
            end
            if ((state == ARB_RESP) && !rsp_ready && (perf_stall != '1)) begin
                perf_stall <= perf_stall + PERF_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_seq_pattern_arbiter.sv
// Self-checking bench for seq_pattern_arbiter (N_REQ=4, DATA_W=1).
// Perf-counter checks are active only when SEQ_ARB_PERF_EN is defined.
module tb_seq_pattern_arbiter;

    localparam int N  = 4;
    localparam int DW = 1;
    localparam int TW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] op_a = '0;
    logic [N*DW-1:0] op_b = '0;
    logic [N*DW-1:0] op_c = '0;
    logic [N-1:0]    gnt;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [TW-1:0]   rsp_tag;
    logic [DW-1:0]   rsp_data;
    logic            busy;
`ifdef SEQ_ARB_PERF_EN
    logic [15:0]     perf_grants;
    logic [15:0]     perf_stall;
`endif

    int checks   = 0;
    int failures = 0;
    int ptr      = 0;
    int m_grants = 0;
    int m_stall  = 0;

    seq_pattern_arbiter #(
        .N_REQ  (N),
        .DATA_W (DW)
    ) dut (
        .blif_clk_net   (clk),
        .blif_reset_net (rst_n),
        .req            (req),
        .op_a           (op_a),
        .op_b           (op_b),
        .op_c           (op_c),
        .gnt            (gnt),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_tag        (rsp_tag),
        .rsp_data       (rsp_data),
        .busy           (busy)
`ifdef SEQ_ARB_PERF_EN
        ,
        .perf_grants    (perf_grants),
        .perf_stall     (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: scan requesters starting at the pointer, wrapping.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] ref_eval(input int w, input logic [N*DW-1:0] a,
                                               input logic [N*DW-1:0] b, input logic [N*DW-1:0] c);
        logic [DW-1:0] ra, rb, rc;
        ra = a[w*DW +: DW];
        rb = b[w*DW +: DW];
        rc = c[w*DW +: DW];
        return (ra & rb) | ~rc;
    endfunction

    task automatic check_perf(input string tag);
`ifdef SEQ_ARB_PERF_EN
        chk({tag, "_perf_grants"}, 32'(perf_grants), 32'(m_grants));
        chk({tag, "_perf_stall"}, 32'(perf_stall), 32'(m_stall));
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ptr = 0;
        m_grants = 0;
        m_stall = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One full transaction from IDLE; the winner drops its request after gnt.
    task automatic txn(input string tag, input int stall);
        int w;
        logic [DW-1:0] exp;
        w = pick(req, ptr);
        exp = ref_eval(w, op_a, op_b, op_c);
        tick();
        chk({tag, "_gnt"}, 32'(gnt), 32'(1) << w);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_valid_early"}, 32'(rsp_valid), 32'd0);
        req[w] = 1'b0;
        ptr = (w + 1) % N;
        tick();
        op_a = N'($urandom);
        op_b = N'($urandom);
        op_c = N'($urandom);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_tag"}, 32'(rsp_tag), 32'(w));
        chk({tag, "_data"}, 32'(rsp_data), 32'(exp));
        chk({tag, "_gnt_resp"}, 32'(gnt), 32'd0);
        rsp_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            tick();
            chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_hold_tag"}, 32'(rsp_tag), 32'(w));
            chk({tag, "_hold_data"}, 32'(rsp_data), 32'(exp));
            chk({tag, "_hold_gnt"}, 32'(gnt), 32'd0);
        end
        m_stall += stall;
        check_perf({tag, "_stalled"});
        rsp_ready = 1'b1;
        tick();
        m_grants++;
        chk({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        check_perf({tag, "_done"});
    endtask

    initial begin
        int exp_order [5];
        int w;

        // 1: reset held with clock running, then released with no requests.
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_tag", 32'(rsp_tag), 32'd0);
        chk("rst_data", 32'(rsp_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_gnt", 32'(gnt), 32'd0);
        chk("post_rst_valid", 32'(rsp_valid), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        check_perf("post_rst");

        // 3: all four requesting continuously -> 0,1,2,3,0 every 3 cycles.
        exp_order = '{0, 1, 2, 3, 0};
        req = 4'b1111;
        rsp_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            w = pick(req, ptr);
            chk("rr_model_order", 32'(w), 32'(exp_order[g]));
            tick();
            chk("rr_gnt", 32'(gnt), 32'(1) << exp_order[g]);
            ptr = (w + 1) % N;
            tick();
            chk("rr_gnt_gap1", 32'(gnt), 32'd0);
            chk("rr_tag", 32'(rsp_tag), 32'(exp_order[g]));
            tick();
            chk("rr_gnt_gap2", 32'(gnt), 32'd0);
            m_grants++;
        end
        check_perf("rr");
        req = '0;
        do_reset();

        // 2: single requester 2, three operand patterns.
        op_a = 4'b0100; op_b = 4'b0100; op_c = 4'b0100; req = 4'b0100;
        txn("p1", 0);
        op_a = 4'b0000; op_b = 4'b0100; op_c = 4'b0100; req = 4'b0100;
        txn("p2", 0);
        op_a = 4'b0000; op_b = 4'b0000; op_c = 4'b0000; req = 4'b0100;
        txn("p3", 0);

        // 4: consumer stalls five cycles in RESP.
        op_a = 4'b0010; op_b = 4'b0010; op_c = 4'b1111; req = 4'b0010;
        txn("stall", 5);

        // 6: requester 3 withdraws while the pointer sits on it; 0 wins.
        op_a = 4'b0100; op_b = 4'b0000; op_c = 4'b0100; req = 4'b0100;
        w = pick(req, ptr);
        tick();
        chk("drop_setup_gnt", 32'(gnt), 32'(1) << w);
        ptr = (w + 1) % N;
        req = 4'b1001;
        rsp_ready = 1'b0;
        tick();
        chk("drop_ptr_model", 32'(ptr), 32'd3);
        m_stall++;
        tick();
        req = 4'b0001;
        op_a = 4'b0001; op_b = 4'b0001; op_c = 4'b0001;
        rsp_ready = 1'b1;
        tick();
        m_grants++;
        chk("drop_idle_gnt", 32'(gnt), 32'd0);
        txn("drop", 0);
        chk("drop_no_g3", 32'(gnt), 32'd0);

        // 5: asynchronous reset while a response is pending.
        op_a = 4'b1000; op_b = 4'b1000; op_c = 4'b1000; req = 4'b1000;
        tick();
        req = 4'b0000;
        tick();
        chk("arst_pre_valid", 32'(rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        ptr = 0;
        m_grants = 0;
        m_stall = 0;
        #1;
        chk("arst_valid", 32'(rsp_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_tag", 32'(rsp_tag), 32'd0);
        chk("arst_data", 32'(rsp_data), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("arst_no_resp", 32'(rsp_valid), 32'd0);
        check_perf("arst");
        op_a = 4'b1010; op_b = 4'b1010; op_c = 4'b0000; req = 4'b1010;
        txn("arst_next", 0);
        req = '0;

        // Randomized traffic with lingering requests and random stalls.
        for (int t = 0; t < 40; t++) begin
            req = req | N'($urandom_range(0, 15));
            if (req == '0) req = N'(1) << $urandom_range(0, N - 1);
            op_a = N'($urandom);
            op_b = N'($urandom);
            op_c = N'($urandom);
            txn("rand", int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
